// File: rtl/eth_pkg.sv
// Shared types and constants for the eth_clk-domain stream arbiter.
package eth_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_HDR, ARB_DATA, ARB_PAD} arb_state_t;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin pick: first asserted request after 'last', wrapping modulo NUM_SRC.
module rr_priority_encoder
    import eth_pkg::*;
#(
    parameter  int unsigned NUM_SRC = 2,
    localparam int unsigned IDW     = id_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDW-1:0]     last,
    output logic [IDW-1:0]     gnt_idx,
    output logic               gnt_valid
);

    logic [2*NUM_SRC-1:0] req_dbl;
    logic [NUM_SRC-1:0]   req_rot;

    // Bit j of req_rot is source (last+1+j) mod NUM_SRC.
    assign req_dbl = {req, req};
    assign req_rot = NUM_SRC'(req_dbl >> (32'(last) + 32'd1));

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            if (!gnt_valid && req_rot[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDW'((32'(last) + 32'd1 + j) % NUM_SRC);
            end
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter: header word, zero-latency payload pass-through,
// and PAD_WORD fill when the granted source starves mid-frame.
module axis_packet_arbiter
    import eth_pkg::*;
#(
    parameter  int unsigned               NUM_SRC              = 2,
    parameter  int unsigned               WORD_BYTES           = 4,
    parameter  int unsigned               PACKET_PAYLOAD_WORDS = 128,
    parameter  int unsigned               STARVE_CYCLES        = 64,
    parameter  logic [WORD_BYTES*8-1:0]   PAD_WORD             = '0,
    localparam int unsigned               DW                   = WORD_BYTES * 8,
    localparam int unsigned               IDW                  = id_width(NUM_SRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC*DW-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]    s_axis_tvalid,
    output logic [NUM_SRC-1:0]    s_axis_tready,
    output logic [DW-1:0]         m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy,
    output logic                  pad_pulse
);

    localparam int unsigned     WCW        = $clog2(PACKET_PAYLOAD_WORDS);
    localparam int unsigned     SCW        = $clog2(STARVE_CYCLES + 1);
    localparam logic [WCW-1:0]  LAST_IDX   = WCW'(PACKET_PAYLOAD_WORDS - 1);
    localparam logic [SCW-1:0]  STARVE_MAX = SCW'(STARVE_CYCLES - 1);

    arb_state_t     state_q, state_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
    logic [15:0]    seq_q, seq_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic           pad_pulse_q, pad_pulse_d;

    logic [IDW-1:0] rr_idx;
    logic           rr_valid;
    logic           sel_valid;
    logic [DW-1:0]  sel_data;
    logic [DW-1:0]  hdr_word;
    logic           accept;

    rr_priority_encoder #(.NUM_SRC(NUM_SRC)) u_rr (
        .req       (s_axis_tvalid),
        .last      (last_grant_q),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (IDW'(i) == grant_q) begin
                sel_valid = s_axis_tvalid[i];
                sel_data  = s_axis_tdata[i*DW +: DW];
            end
        end
        hdr_word            = '0;
        hdr_word[DW-1 -: 32] = {HDR_MAGIC, 8'(grant_q), seq_q};
    end

    // Payload ready is a combinational copy of downstream ready for the granted source only.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        s_axis_tready = '0;
        unique case (state_q)
            ARB_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_word;
            end
            ARB_DATA: begin
                m_axis_tvalid = sel_valid;
                m_axis_tdata  = sel_data;
                for (int unsigned i = 0; i < NUM_SRC; i++) begin
                    if (IDW'(i) == grant_q) s_axis_tready[i] = m_axis_tready;
                end
            end
            ARB_PAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = PAD_WORD;
            end
            default: ;
        endcase
    end

    assign accept       = m_axis_tvalid && m_axis_tready;
    assign m_axis_tlast = m_axis_tvalid && (state_q != ARB_IDLE) && (word_cnt_q == LAST_IDX);
    assign busy         = (state_q != ARB_IDLE);
    assign grant_id     = grant_q;
    assign pad_pulse    = pad_pulse_q;

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        starve_cnt_d = starve_cnt_q;
        seq_d        = seq_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        pad_pulse_d  = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                word_cnt_d   = '0;
                starve_cnt_d = '0;
                if (rr_valid) begin
                    grant_d      = rr_idx;
                    last_grant_d = rr_idx;
                    state_d      = ARB_HDR;
                end
            end
            ARB_HDR: begin
                if (accept) begin
                    word_cnt_d = WCW'(1);
                    state_d    = ARB_DATA;
                end
            end
            ARB_DATA, ARB_PAD: begin
                // An accepted word always wins over the starve threshold.
                if (accept) begin
                    starve_cnt_d = '0;
                    if (word_cnt_q == LAST_IDX) begin
                        word_cnt_d = '0;
                        seq_d      = seq_q + 16'd1;
                        state_d    = ARB_IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end else if (state_q == ARB_DATA && !sel_valid) begin
                    if (starve_cnt_q >= STARVE_MAX) begin
                        starve_cnt_d = '0;
                        pad_pulse_d  = 1'b1;
                        state_d      = ARB_PAD;
                    end else begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            word_cnt_q   <= '0;
            starve_cnt_q <= '0;
            seq_q        <= '0;
            last_grant_q <= IDW'(NUM_SRC - 1);
            grant_q      <= '0;
            pad_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            seq_q        <= seq_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            pad_pulse_q  <= pad_pulse_d;
        end
    end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Scoreboard bench for axis_packet_arbiter: directed frames push expected beats,
// a negedge monitor pops and compares every accepted output word.
module tb_axis_packet_arbiter;

    localparam int          PPW = 128;
    localparam logic [31:0] PAD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_tdata;
    logic [1:0]  s_tvalid, s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [0:0]  grant_id;
    logic        busy, pad_pulse;

    always #5 clk = ~clk;

    axis_packet_arbiter #(
        .NUM_SRC              (2),
        .WORD_BYTES           (4),
        .PACKET_PAYLOAD_WORDS (PPW),
        .STARVE_CYCLES        (64),
        .PAD_WORD             (PAD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .grant_id      (grant_id),
        .busy          (busy),
        .pad_pulse     (pad_pulse)
    );

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] src0_q[$];
    logic [31:0] src1_q[$];
    int          word_ctr[2];
    int          passed = 0;
    int          total  = 0;
    int          cyc    = 0;
    bit          ready_rand = 1'b0;
    logic [1:0]  xfer_src = '0;

    int          frame_pos = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    bit          after_last = 1'b0;
    int          hdr_cyc = -1, prev_hdr_cyc = -1;
    int          last_src_cyc = 0, pad_cyc = 0;
    int          pad_count = 0;
    bit          in_pad = 1'b0;
    int          pad_rdy_viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push_frame(input int src, input int ndata, input logic [15:0] seq);
        beat_t       b;
        logic [31:0] w;
        b.last = 1'b0;
        b.data = {8'hA5, 8'(src), seq};
        exp_q.push_back(b);
        for (int k = 1; k < PPW; k++) begin
            if (k <= ndata) begin
                w = ((src == 0) ? 32'h1000_0000 : 32'h2000_0000) + 32'(word_ctr[src]);
                word_ctr[src]++;
                if (src == 0) src0_q.push_back(w);
                else          src1_q.push_back(w);
            end else begin
                w = PAD;
            end
            b.last = (k == PPW - 1);
            b.data = w;
            exp_q.push_back(b);
        end
    endtask

    task automatic flush_all();
        exp_q.delete();
        src0_q.delete();
        src1_q.delete();
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL %s: timeout with %0d beats outstanding, expected 0", name, exp_q.size());
            flush_all();
        end
        repeat (3) @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        flush_all();
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    // Source and sink driver: pops a source word after each observed transfer.
    initial begin
        logic [31:0] tmp;
        s_tvalid = '0;
        s_tdata  = '0;
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (xfer_src[0] && src0_q.size() > 0) tmp = src0_q.pop_front();
            if (xfer_src[1] && src1_q.size() > 0) tmp = src1_q.pop_front();
            s_tvalid[0]     = (src0_q.size() > 0);
            s_tdata[31:0]   = (src0_q.size() > 0) ? src0_q[0] : 32'h0;
            s_tvalid[1]     = (src1_q.size() > 0);
            s_tdata[63:32]  = (src1_q.size() > 0) ? src1_q[0] : 32'h0;
            m_tready        = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        beat_t e;
        xfer_src = s_tvalid & s_tready;
        if (rst) begin
            frame_pos  = 0;
            prev_stall = 1'b0;
            after_last = 1'b0;
            in_pad     = 1'b0;
        end else begin
            if (pad_pulse) begin
                pad_count++;
                pad_cyc = cyc;
                in_pad  = 1'b1;
            end
            if (in_pad && s_tready != 2'b00) pad_rdy_viol++;
            if (after_last) begin
                check("idle_after_tlast", {62'd0, busy, m_tvalid}, 64'd0);
                after_last = 1'b0;
            end
            if (prev_stall) check("hold_while_stalled", {31'd0, m_tvalid, m_tdata}, {31'd0, 1'b1, prev_data});
            if (m_tlast && !m_tvalid) check("tlast_without_valid", 64'(m_tlast), 64'd0);
            for (int i = 0; i < 2; i++) begin
                if (s_tready[i]) check($sformatf("passthrough_src%0d", i),
                                       {31'd0, m_tvalid, m_tdata},
                                       {31'd0, s_tvalid[i], s_tdata[i*32 +: 32]});
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_beat: got %0h last=%0b, expected no beat", m_tdata, m_tlast);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("beat[%0d]", frame_pos), {31'd0, m_tlast, m_tdata}, 64'(e));
                    if (frame_pos == 0) begin
                        check("grant_id_at_hdr", 64'(grant_id), 64'(e.data[23:16]));
                        prev_hdr_cyc = hdr_cyc;
                        hdr_cyc      = cyc;
                    end
                end
                if (frame_pos > 0 && !in_pad) last_src_cyc = cyc;
                if (m_tlast) begin
                    frame_pos  = 0;
                    after_last = 1'b1;
                    in_pad     = 1'b0;
                end else begin
                    frame_pos++;
                end
                prev_stall = 1'b0;
            end else begin
                prev_stall = m_tvalid;
                prev_data  = m_tdata;
            end
        end
    end

    initial begin
        int n;
        word_ctr[0] = 0;
        word_ctr[1] = 0;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", {25'd0, m_tvalid, m_tdata, m_tlast, grant_id, busy, pad_pulse, s_tready}, 64'd0);
        @(posedge clk);
        #3 rst = 1'b0;

        // Single source, back-to-back frames with one IDLE cycle between.
        push_frame(0, PPW - 1, 16'h0000);
        push_frame(0, PPW - 1, 16'h0001);
        wait_drain(1000, "t1_drain");
        check("t1_header_spacing", 64'(hdr_cyc - prev_hdr_cyc), 64'd129);

        // Both sources always valid: grants alternate starting at src0.
        do_reset();
        push_frame(0, PPW - 1, 16'h0000);
        push_frame(1, PPW - 1, 16'h0001);
        push_frame(0, PPW - 1, 16'h0002);
        wait_drain(1500, "t2_drain");

        // Starvation after 10 words: PAD fill, src0 refilled while PAD runs.
        do_reset();
        pad_count    = 0;
        pad_rdy_viol = 0;
        push_frame(0, 10, 16'h0000);
        n = 0;
        while (pad_count == 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #3;
        check("t3_pad_delay", 64'(pad_cyc - last_src_cyc), 64'd65);
        push_frame(0, PPW - 1, 16'h0001);
        wait_drain(1000, "t3_drain");
        check("t3_pad_pulse_count", 64'(pad_count), 64'd1);
        check("t3_src_ready_in_pad", 64'(pad_rdy_viol), 64'd0);

        // Random downstream back-pressure, including a padded frame.
        do_reset();
        ready_rand = 1'b1;
        push_frame(0, PPW - 1, 16'h0000);
        push_frame(1, PPW - 1, 16'h0001);
        push_frame(0, PPW - 1, 16'h0002);
        push_frame(1, PPW - 1, 16'h0003);
        push_frame(0, 5, 16'h0004);
        wait_drain(5000, "t4_drain");
        ready_rand = 1'b0;

        // Asynchronous reset mid-frame, then a fresh frame with seq restarted.
        do_reset();
        push_frame(1, PPW - 1, 16'h0000);
        n = 0;
        while (frame_pos < 50 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #3 rst = 1'b1;
        #1 check("t5_async_reset_outputs",
                 {25'd0, m_tvalid, m_tdata, m_tlast, grant_id, busy, pad_pulse, s_tready}, 64'd0);
        flush_all();
        @(posedge clk);
        #3 rst = 1'b0;
        push_frame(0, PPW - 1, 16'h0000);
        wait_drain(1000, "t5_drain");

        // Sequence number wrap from 0xFFFF to 0x0000.
        @(posedge clk);
        #3 force dut.seq_q = 16'hFFFF;
        @(posedge clk);
        #3 release dut.seq_q;
        push_frame(0, PPW - 1, 16'hFFFF);
        push_frame(0, PPW - 1, 16'h0000);
        wait_drain(1000, "t6_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
